car_motion_ctrl: RTL and testbench

Converts the four debounced direction-button levels into the car sprite's top-left position in screen pixels. It sits directly downstream of the per-button debouncers, in the `clk_sys` domain, and feeds the frame-buffer sprite renderer. A tap moves the car by one step. A held button auto-repeats after an initial delay. Position changes only on the frame tick, so the renderer never sees a mid-frame move, and the car is clamped to the visible area.

---
 rtl/car_motion_ctrl.sv | 154 +++++++++++++++
 tb/tb_car_motion_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/car_motion_ctrl.sv
// Car sprite motion: debounced direction buttons to a clamped sprite position.
// Taps step once, held buttons auto-repeat, and moves land only on frame ticks.
module car_motion_ctrl #(
  parameter int H_RES         = 640,
  parameter int V_RES         = 480,
  parameter int CAR_W         = 32,
  parameter int CAR_H         = 16,
  parameter int STEP          = 4,
  parameter int REPEAT_DELAY  = 20,
  parameter int REPEAT_PERIOD = 2,
  parameter int X_INIT        = 304,
  parameter int Y_INIT        = 232
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       btn_up,
  input  logic                       btn_down,
  input  logic                       btn_left,
  input  logic                       btn_right,
  input  logic                       frame_tick,
  output logic [$clog2(H_RES)-1:0]   car_x,
  output logic [$clog2(V_RES)-1:0]   car_y,
  output logic                       moved
);

  localparam int XW    = $clog2(H_RES);
  localparam int YW    = $clog2(V_RES);
  localparam int X_MAX = H_RES - CAR_W;
  localparam int Y_MAX = V_RES - CAR_H;
  localparam int CMAX  = (REPEAT_DELAY > REPEAT_PERIOD) ?
                         REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CW    = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [CW-1:0] DLY1 = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] PER1 = CW'(REPEAT_PERIOD - 1);

  localparam logic [XW:0] STEP_X = (XW+1)'(STEP);
  localparam logic [YW:0] STEP_Y = (YW+1)'(STEP);
  localparam logic [XW:0] XMAX_E = (XW+1)'(X_MAX);
  localparam logic [YW:0] YMAX_E = (YW+1)'(Y_MAX);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT
  } state_t;

  // bit order: 0 up, 1 down, 2 left, 3 right
  logic [3:0]    btn;
  logic [3:0]    prev;
  logic [3:0]    rise;
  logic [3:0]    live;
  logic [3:0]    req;
  logic [3:0]    pend;
  logic [3:0]    eff;
  state_t        st  [4];
  logic [CW-1:0] cnt [4];

  assign btn = {btn_right, btn_left, btn_down, btn_up};

  always_comb begin
    rise = btn & ~prev;
    live = '0;
    for (int i = 0; i < 4; i++) begin
      live[i] = (st[i] != IDLE) && btn[i] &&
                frame_tick && (cnt[i] == '0);
    end
    req = rise | live;
    eff = pend | req;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev <= '0;
      pend <= '0;
      for (int i = 0; i < 4; i++) begin
        st[i]  <= IDLE;
        cnt[i] <= '0;
      end
    end else begin
      prev <= btn;
      pend <= frame_tick ? '0 : (pend | req);
      for (int i = 0; i < 4; i++) begin
        unique case (st[i])
          IDLE: begin
            if (rise[i]) begin
              st[i]  <= HOLD;
              cnt[i] <= DLY1;
            end
          end
          HOLD, REPEAT: begin
            // release wins over a coincident tick
            if (!btn[i]) begin
              st[i]  <= IDLE;
              cnt[i] <= '0;
            end else if (frame_tick) begin
              if (cnt[i] == '0) begin
                st[i]  <= REPEAT;
                cnt[i] <= PER1;
              end else begin
                cnt[i] <= cnt[i] - 1'b1;
              end
            end
          end
          default: begin
            st[i]  <= IDLE;
            cnt[i] <= '0;
          end
        endcase
      end
    end
  end

  logic [XW:0]   xe, xl, xr;
  logic [YW:0]   ye, yu, yd;
  logic [XW-1:0] nx;
  logic [YW-1:0] ny;

  always_comb begin
    xe = {1'b0, car_x};
    ye = {1'b0, car_y};
    xl = xe - STEP_X;
    xr = xe + STEP_X;
    yu = ye - STEP_Y;
    yd = ye + STEP_Y;
    nx = car_x;
    ny = car_y;
    if (eff[2] && !eff[3]) begin
      nx = (xe < STEP_X) ? '0 : xl[XW-1:0];
    end else if (eff[3] && !eff[2]) begin
      nx = (xr > XMAX_E) ? XMAX_E[XW-1:0] : xr[XW-1:0];
    end
    if (eff[0] && !eff[1]) begin
      ny = (ye < STEP_Y) ? '0 : yu[YW-1:0];
    end else if (eff[1] && !eff[0]) begin
      ny = (yd > YMAX_E) ? YMAX_E[YW-1:0] : yd[YW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      car_x <= XW'(X_INIT);
      car_y <= YW'(Y_INIT);
      moved <= 1'b0;
    end else if (frame_tick) begin
      car_x <= nx;
      car_y <= ny;
      moved <= (nx != car_x) || (ny != car_y);
    end else begin
      moved <= 1'b0;
    end
  end

endmodule

// File: tb/tb_car_motion_ctrl.sv
// Bench for car_motion_ctrl: directed scenarios plus a randomized run
// against a tick-counting reference model on three parameterizations.
module tb_car_motion_ctrl;

  localparam int STEP = 4;
  localparam int DLY  = 20;
  localparam int PER  = 2;
  localparam int XMAX = 608;
  localparam int YMAX = 464;
  localparam int YINI = 232;

  localparam logic [3:0] U = 4'b0001;
  localparam logic [3:0] D = 4'b0010;
  localparam logic [3:0] L = 4'b0100;
  localparam logic [3:0] R = 4'b1000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] b   = '0;
  logic       tick = 1'b0;
  logic [9:0] cx [3];
  logic [8:0] cy [3];
  logic       mv [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  car_motion_ctrl u0 (
    .clk(clk), .rst(rst),
    .btn_up(b[0]), .btn_down(b[1]),
    .btn_left(b[2]), .btn_right(b[3]),
    .frame_tick(tick),
    .car_x(cx[0]), .car_y(cy[0]), .moved(mv[0])
  );

  car_motion_ctrl #(.X_INIT(2)) u1 (
    .clk(clk), .rst(rst),
    .btn_up(b[0]), .btn_down(b[1]),
    .btn_left(b[2]), .btn_right(b[3]),
    .frame_tick(tick),
    .car_x(cx[1]), .car_y(cy[1]), .moved(mv[1])
  );

  car_motion_ctrl #(.X_INIT(606)) u2 (
    .clk(clk), .rst(rst),
    .btn_up(b[0]), .btn_down(b[1]),
    .btn_left(b[2]), .btn_right(b[3]),
    .frame_tick(tick),
    .car_x(cx[2]), .car_y(cy[2]), .moved(mv[2])
  );

  // reference model: counts ticks since press instead of tracking FSMs
  int   xinit [3] = '{304, 2, 606};
  int   mx [3];
  int   my [3];
  bit   mmv [3];
  bit [3:0] mprev, mhold, mpend;
  int   mn [4];

  task automatic model(input logic [3:0] bv, input logic t,
                       input logic r);
    bit [3:0] reqs;
    bit [3:0] eff;
    bit rise;
    int x, y;
    if (r) begin
      mprev = '0; mhold = '0; mpend = '0;
      for (int i = 0; i < 4; i++) mn[i] = 0;
      for (int k = 0; k < 3; k++) begin
        mx[k] = xinit[k]; my[k] = YINI; mmv[k] = 0;
      end
      return;
    end
    reqs = '0;
    for (int i = 0; i < 4; i++) begin
      rise = bv[i] && !mprev[i];
      if (t && mhold[i] && bv[i]) begin
        mn[i]++;
        if (mn[i] >= DLY && (mn[i] - DLY) % PER == 0) reqs[i] = 1;
      end
      if (rise) begin
        mhold[i] = 1; mn[i] = 0; reqs[i] = 1;
      end
      if (!bv[i]) mhold[i] = 0;
    end
    mprev = bv;
    if (t) begin
      eff = mpend | reqs;
      mpend = '0;
      for (int k = 0; k < 3; k++) begin
        x = mx[k]; y = my[k];
        if (eff[0] && !eff[1]) y = (y < STEP) ? 0 : y - STEP;
        else if (eff[1] && !eff[0]) y = (y + STEP > YMAX) ? YMAX : y + STEP;
        if (eff[2] && !eff[3]) x = (x < STEP) ? 0 : x - STEP;
        else if (eff[3] && !eff[2]) x = (x + STEP > XMAX) ? XMAX : x + STEP;
        mmv[k] = (x != mx[k]) || (y != my[k]);
        mx[k] = x; my[k] = y;
      end
    end else begin
      mpend = mpend | reqs;
      for (int k = 0; k < 3; k++) mmv[k] = 0;
    end
  endtask

  task automatic cyc(input logic [3:0] bv, input logic t);
    b = bv;
    tick = t;
    @(posedge clk);
    model(bv, t, rst);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc('0, 1'b0);
    cyc('0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (cx[0] !== 10'd304 || cy[0] !== 9'd232 || mv[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_u0: got x=%0d y=%0d mv=%0b want 304 232 0",
               cx[0], cy[0], mv[0]);
    end
    checks++;
    if (cx[1] !== 10'd2 || cx[2] !== 10'd606) begin
      errors++;
      $display("FAIL reset_init: got x1=%0d x2=%0d want 2 606",
               cx[1], cx[2]);
    end
  endtask

  task automatic test_tap();
    int pulses = 0;
    do_reset();
    repeat (3) cyc(R, 1'b0);
    repeat (2) cyc('0, 1'b0);
    cyc('0, 1'b1);
    checks++;
    if (cx[0] !== 10'd308 || mv[0] !== 1'b1) begin
      errors++;
      $display("FAIL tap_step: got x=%0d mv=%0b want 308 1", cx[0], mv[0]);
    end
    for (int f = 0; f < 3; f++) begin
      repeat (3) begin cyc('0, 1'b0); pulses += mv[0]; end
      cyc('0, 1'b1);
      pulses += mv[0];
    end
    checks++;
    if (cx[0] !== 10'd308 || pulses != 0) begin
      errors++;
      $display("FAIL tap_hold: got x=%0d pulses=%0d want 308 0",
               cx[0], pulses);
    end
  endtask

  task automatic test_repeat();
    int pulses = 0;
    bit want;
    do_reset();
    cyc(D, 1'b0);
    for (int f = 1; f <= 30; f++) begin
      repeat (3) begin cyc(D, 1'b0); pulses += mv[0]; end
      cyc(D, 1'b1);
      pulses += mv[0];
      want = (f == 1) || (f >= DLY && (f - DLY) % PER == 0);
      checks++;
      if (mv[0] !== want) begin
        errors++;
        $display("FAIL repeat_tick%0d: got mv=%0b want %0b", f, mv[0], want);
      end
    end
    checks++;
    if (cy[0] !== 9'd260 || pulses != 7) begin
      errors++;
      $display("FAIL repeat_total: got y=%0d pulses=%0d want 260 7",
               cy[0], pulses);
    end
    cyc('0, 1'b0);
  endtask

  task automatic test_clamp();
    do_reset();
    cyc(R, 1'b0); cyc('0, 1'b0); cyc('0, 1'b1);
    checks++;
    if (cx[2] !== 10'd608 || mv[2] !== 1'b1) begin
      errors++;
      $display("FAIL clamp_right: got x=%0d mv=%0b want 608 1", cx[2], mv[2]);
    end
    do_reset();
    cyc(L, 1'b0); cyc('0, 1'b0); cyc('0, 1'b1);
    checks++;
    if (cx[1] !== 10'd0 || mv[1] !== 1'b1 || cx[0] !== 10'd300) begin
      errors++;
      $display("FAIL clamp_left1: got x1=%0d mv1=%0b x0=%0d want 0 1 300",
               cx[1], mv[1], cx[0]);
    end
    cyc(L, 1'b0); cyc('0, 1'b0); cyc('0, 1'b1);
    checks++;
    if (cx[1] !== 10'd0 || mv[1] !== 1'b0) begin
      errors++;
      $display("FAIL clamp_left2: got x=%0d mv=%0b want 0 0", cx[1], mv[1]);
    end
  endtask

  task automatic test_opposite();
    do_reset();
    cyc(U | D, 1'b0); cyc('0, 1'b1);
    checks++;
    if (cy[0] !== 9'd232 || cx[0] !== 10'd304 || mv[0] !== 1'b0) begin
      errors++;
      $display("FAIL opposite: got x=%0d y=%0d mv=%0b want 304 232 0",
               cx[0], cy[0], mv[0]);
    end
    cyc(U | R, 1'b0); cyc('0, 1'b1);
    checks++;
    if (cy[0] !== 9'd228 || cx[0] !== 10'd308 || mv[0] !== 1'b1) begin
      errors++;
      $display("FAIL diagonal: got x=%0d y=%0d mv=%0b want 308 228 1",
               cx[0], cy[0], mv[0]);
    end
  endtask

  task automatic test_coincide();
    int first = -1;
    do_reset();
    cyc('0, 1'b0);
    cyc(L, 1'b1);
    checks++;
    if (cx[0] !== 10'd300 || mv[0] !== 1'b1) begin
      errors++;
      $display("FAIL coincide_step: got x=%0d mv=%0b want 300 1",
               cx[0], mv[0]);
    end
    for (int f = 1; f <= 25; f++) begin
      repeat (3) cyc(L, 1'b0);
      cyc(L, 1'b1);
      if (mv[0] && first < 0) first = f;
    end
    checks++;
    if (first != DLY) begin
      errors++;
      $display("FAIL coincide_next: got tick %0d want %0d", first, DLY);
    end
    cyc('0, 1'b0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    cyc(R, 1'b0);
    for (int f = 1; f <= 25; f++) begin
      repeat (3) cyc(R, 1'b0);
      cyc(R, 1'b1);
    end
    checks++;
    if (cx[0] !== 10'd320) begin
      errors++;
      $display("FAIL midhold_pre: got x=%0d want 320", cx[0]);
    end
    rst = 1'b1;
    cyc(R, 1'b0);
    rst = 1'b0;
    checks++;
    if (cx[0] !== 10'd304 || cy[0] !== 9'd232 || mv[0] !== 1'b0) begin
      errors++;
      $display("FAIL midhold_rst: got x=%0d y=%0d mv=%0b want 304 232 0",
               cx[0], cy[0], mv[0]);
    end
    cyc(R, 1'b0); cyc(R, 1'b0); cyc(R, 1'b1);
    checks++;
    if (cx[0] !== 10'd308 || mv[0] !== 1'b1) begin
      errors++;
      $display("FAIL midhold_step: got x=%0d mv=%0b want 308 1",
               cx[0], mv[0]);
    end
    for (int f = 0; f < 5; f++) begin
      repeat (3) cyc(R, 1'b0);
      cyc(R, 1'b1);
    end
    checks++;
    if (cx[0] !== 10'd308) begin
      errors++;
      $display("FAIL midhold_after: got x=%0d want 308", cx[0]);
    end
    cyc('0, 1'b0);
  endtask

  task automatic test_random();
    logic [3:0] bv = '0;
    int gap;
    do_reset();
    gap = $urandom_range(1, 6);
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 9) == 0) bv[i] = ~bv[i];
      rst = ($urandom_range(0, 599) == 0);
      gap--;
      cyc(bv, gap == 0);
      if (gap == 0) gap = $urandom_range(1, 6);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (cx[k] !== 10'(mx[k]) || cy[k] !== 9'(my[k]) ||
            mv[k] !== mmv[k]) begin
          errors++;
          $display("FAIL random_u%0d c%0d: got %0d/%0d/%0b want %0d/%0d/%0b",
                   k, c, cx[k], cy[k], mv[k], mx[k], my[k], mmv[k]);
        end
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_tap();
    test_repeat();
    test_clamp();
    test_opposite();
    test_coincide();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
